// File: rtl/mdu_div.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU: one quotient bit per cycle,
// start/busy/done handshake, flush via div_cancel, results held for HI/LO writeback.
module mdu_div #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             div_start,
   input  logic             div_signed,
   input  logic [WIDTH-1:0] div_src1,
   input  logic [WIDTH-1:0] div_src2,
   input  logic             div_cancel,
   output logic             div_busy,
   output logic             div_done,
   output logic [WIDTH-1:0] div_quotient,
   output logic [WIDTH-1:0] div_remainder,
   output logic             div_by_zero
);

   // state | meaning
   // IDLE  | waiting for div_start, outputs hold last result
   // CALC  | WIDTH restoring iterations, one quotient bit per cycle
   // FIXUP | sign correction / divide-by-zero override, output registers written
   // DONE  | div_done pulse for one cycle
   typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

   localparam int CW = $clog2(WIDTH + 1);

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH-1:0] src1_orig;
   logic             is_signed;
   logic             sign_q;
   logic             sign_r;
   logic             zero_div;

   logic [WIDTH:0]   shifted;
   logic             trial_ge;
   logic [WIDTH-1:0] trial_diff;

   // The shifted remainder needs WIDTH+1 bits; after a successful subtract it fits in WIDTH again.
   always_comb begin
      shifted    = {rem, dvd[WIDTH-1]};
      trial_ge   = (shifted >= {1'b0, dvs});
      trial_diff = shifted[WIDTH-1:0] - dvs;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         rem           <= '0;
         dvd           <= '0;
         dvs           <= '0;
         src1_orig     <= '0;
         is_signed     <= 1'b0;
         sign_q        <= 1'b0;
         sign_r        <= 1'b0;
         zero_div      <= 1'b0;
         div_busy      <= 1'b0;
         div_done      <= 1'b0;
         div_quotient  <= '0;
         div_remainder <= '0;
         div_by_zero   <= 1'b0;
      end else if (div_cancel) begin
         state    <= IDLE;
         div_busy <= 1'b0;
         div_done <= 1'b0;
      end else begin
         div_done <= 1'b0;
         case (state)
            IDLE: begin
               if (div_start) begin
                  // 0x80000000 negates to itself and is then read as unsigned 2^31
                  dvd       <= (div_signed && div_src1[WIDTH-1]) ? -div_src1 : div_src1;
                  dvs       <= (div_signed && div_src2[WIDTH-1]) ? -div_src2 : div_src2;
                  src1_orig <= div_src1;
                  is_signed <= div_signed;
                  sign_q    <= div_signed & (div_src1[WIDTH-1] ^ div_src2[WIDTH-1]);
                  sign_r    <= div_signed & div_src1[WIDTH-1];
                  zero_div  <= (div_src2 == '0);
                  rem       <= '0;
                  cnt       <= '0;
                  div_busy  <= 1'b1;
                  state     <= CALC;
               end
            end
            CALC: begin
               rem <= trial_ge ? trial_diff : shifted[WIDTH-1:0];
               dvd <= {dvd[WIDTH-2:0], trial_ge};
               cnt <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) state <= FIXUP;
            end
            FIXUP: begin
               if (zero_div) begin
                  div_quotient  <= '1;
                  div_remainder <= src1_orig;
                  div_by_zero   <= 1'b1;
               end else begin
                  div_quotient  <= (is_signed && sign_q) ? -dvd : dvd;
                  div_remainder <= (is_signed && sign_r) ? -rem : rem;
                  div_by_zero   <= 1'b0;
               end
               div_busy <= 1'b0;
               div_done <= 1'b1;
               state    <= DONE;
            end
            DONE: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/mdu_div.md
# mdu_div

Iterative 32-bit radix-2 restoring divider implementing MIPS DIV/DIVU for the execute stage, alongside the single-cycle ALU. It takes operands through a start/busy/done handshake, iterates one quotient bit per cycle, and delivers the quotient and remainder for the HI/LO writeback path. The pipeline stalls while `div_busy` is high. A flush input aborts an in-flight operation.

## Interface
- `WIDTH`, 32 — operand width; quotient and remainder widths match it; iteration count equals WIDTH.
- `clk`  input  1  — single clock; all state changes on the rising edge.
- `rst`  input  1  — asynchronous, active-high reset.
- `div_start`  input  1  — request; sampled only in IDLE.
- `div_signed`  input  1  — 1 = DIV (two's complement), 0 = DIVU; captured with start.
- `div_src1`  input  WIDTH  — dividend; captured with start.
- `div_src2`  input  WIDTH  — divisor; captured with start.
- `div_cancel`  input  1  — flush; aborts any operation and drops the result.
- `div_busy`  output  1  — high in CALC and FIXUP.
- `div_done`  output  1  — one-cycle pulse; results valid in that cycle and held afterwards.
- `div_quotient`  output  WIDTH  — registered quotient (LO).
- `div_remainder`  output  WIDTH  — registered remainder (HI).
- `div_by_zero`  output  1  — registered; set when the captured divisor was 0.

## Operation
- States: IDLE, CALC, FIXUP, DONE.
- IDLE → CALC on `div_start & ~div_cancel`. At this transition the block captures the signedness and the operand magnitudes. In signed mode a negative operand is negated; 0x80000000 stays 0x80000000 and is treated as unsigned 2^31. It also captures sign_q = src1[31]^src2[31] and sign_r = src1[31] (signed mode only), sets the zero-divisor flag, clears the partial remainder and sets iteration count = 0.
- CALC, each cycle:
  - Shift {rem, dividend} left by 1.
  - Trial subtract: rem − divisor, computed WIDTH+1 bits wide.
  - If the result is non-negative, rem takes the difference and the new quotient bit is 1. Otherwise the quotient bit is 0.
  - Increment the count. After WIDTH iterations, go to FIXUP.
- FIXUP (one cycle):
  - If the divisor was zero: quotient = all ones, remainder = original `div_src1` unmodified, `div_by_zero` = 1.
  - Otherwise, in signed mode, negate the quotient if sign_q and negate the remainder if sign_r. Results are written to the output registers and `div_by_zero` = 0.
  - Go to DONE.
- DONE (one cycle): `div_done` = 1, then go to IDLE. A start in DONE is ignored.
- Overflow case −2^31 / −1 (signed): quotient 0x80000000, remainder 0. No flag.
- `div_start` outside IDLE is ignored. Callers must hold their request until the block is idle.
- `div_cancel` in any state moves the block to IDLE at the next edge. Output registers are not updated and no `div_done` pulse is produced. Cancel and start together in IDLE: cancel wins and the start is dropped.
- Output registers change only in FIXUP. They hold between operations.

## Timing
- Reset (asynchronous, immediate):
  - State IDLE, count 0.
  - `div_busy` 0, `div_done` 0, `div_quotient` 0, `div_remainder` 0, `div_by_zero` 0.
- Latency: start accepted at edge E0 → CALC for WIDTH cycles (edges E1..E32) → FIXUP at edge E33 writes the results → `div_done` high during cycle E33–E34.
  - That is, done rises WIDTH+1 = 33 edges after acceptance.
  - Next start is accepted at E34 at the earliest.
- `div_busy` rises at E0 and falls at E33. It is 0 in DONE and IDLE.
- Reset asserted mid-operation: the block returns to IDLE immediately, with no done pulse and outputs cleared.
- `div_done` is never high for more than one consecutive cycle.

## Test plan
- Unsigned 100 / 7, `div_signed`=0 → done 33 edges after start, quotient 14, remainder 2, `div_by_zero` 0, busy high for exactly 33 cycles.
- Signed −7 / 2 (0xFFFFFFF9, 2) → quotient 0xFFFFFFFD (−3), remainder 0xFFFFFFFF (−1). Signed 7 / −2 → quotient −3, remainder 1.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. Unsigned 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0.
- Divide by zero, src1 = 0x12345678, both modes → quotient 0xFFFFFFFF, remainder 0x12345678, `div_by_zero` 1, same 33-edge latency.
- `div_cancel` at iteration 10 → IDLE next edge, no done pulse, outputs keep the previous result. Start during busy → ignored. Start + cancel together in IDLE → not accepted.
- Back-to-back: new start held from DONE → accepted at first IDLE cycle. Asynchronous `rst` mid-CALC → all outputs 0 without waiting for a clock edge.
